// File: rtl/run_ctrl_if.sv
// Run-controller signal bundle: the top level/core side is the master, the
// controller is the slave.
interface run_ctrl_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned PSEL_W = 1,
  parameter int unsigned CYC_W  = 16
);
  logic              start;
  logic [PSEL_W-1:0] prog_sel;
  logic [PC_W-1:0]   pc;
  logic              core_rst;
  logic              core_en;
  logic [PC_W-1:0]   base_pc;
  logic              done;
  logic              timeout;
  logic              busy;
  logic [CYC_W-1:0]  cycles;

  modport master (
    output start, prog_sel, pc,
    input  core_rst, core_en, base_pc, done, timeout, busy, cycles
  );

  modport slave (
    input  start, prog_sel, pc,
    output core_rst, core_en, base_pc, done, timeout, busy, cycles
  );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: program select, timed core reset, run-cycle counting,
// end-PC completion, abort on start loss and optional timeout.
module run_ctrl #(
  parameter int unsigned                 PC_W       = 8,
  parameter int unsigned                 NUM_PROGS  = 1,
  parameter int unsigned                 PSEL_W     = 1,
  parameter logic [NUM_PROGS*PC_W-1:0]   PROG_BASE  = 8'd0,
  parameter logic [NUM_PROGS*PC_W-1:0]   PROG_END   = 8'd190,
  parameter int unsigned                 RST_CYCLES = 1,
  parameter int unsigned                 CYC_W      = 16,
  parameter int unsigned                 MAX_CYCLES = 0
) (
  input logic       clk,
  input logic       rst,
  run_ctrl_if.slave bus
);

  localparam int unsigned      RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W:0]   MAX_V   = (CYC_W+1)'(MAX_CYCLES);

  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0]  cycles_q, cycles_d;
  logic [PC_W-1:0]   base_pc_q, base_pc_d;
  logic [PC_W-1:0]   end_pc_q, end_pc_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              core_rst_q, core_en_q, busy_q;

  logic [PSEL_W-1:0] sel_in;
  logic [PC_W-1:0]   base_sel, end_sel;
  logic [CYC_W:0]    cyc_inc;
  logic              limit_hit;

  assign sel_in = bus.prog_sel;

  // Out-of-range selections fall through to program 0.
  always_comb begin
    base_sel = PROG_BASE[PC_W-1:0];
    end_sel  = PROG_END[PC_W-1:0];
    for (int unsigned i = 0; i < NUM_PROGS; i++) begin
      if (32'(sel_in) == i) begin
        base_sel = PROG_BASE[i*PC_W +: PC_W];
        end_sel  = PROG_END[i*PC_W +: PC_W];
      end
    end
  end

  assign cyc_inc   = {1'b0, cycles_q} + {{CYC_W{1'b0}}, 1'b1};
  assign limit_hit = (MAX_CYCLES != 0) && (cyc_inc == MAX_V);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cycles_d  = cycles_q;
    base_pc_d = base_pc_q;
    end_pc_d  = end_pc_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        done_d    = 1'b0;
        timeout_d = 1'b0;
        if (bus.start) begin
          state_d   = RST;
          base_pc_d = base_sel;
          end_pc_d  = end_sel;
          cycles_d  = '0;
          rst_cnt_d = RC_LOAD;
        end
      end
      RST: begin
        if (!bus.start)          state_d = IDLE;
        else if (rst_cnt_q == '0) state_d = RUN;
        else                     rst_cnt_d = rst_cnt_q - RC_W'(1);
      end
      RUN: begin
        cycles_d = (&cycles_q) ? cycles_q : cycles_q + CYC_W'(1);
        if (!bus.start) begin
          state_d = IDLE;
        end else if (bus.pc == end_pc_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (limit_hit) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (!bus.start) begin
          state_d   = IDLE;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change only on edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rst_cnt_q  <= '0;
      cycles_q   <= '0;
      base_pc_q  <= PROG_BASE[PC_W-1:0];
      end_pc_q   <= PROG_END[PC_W-1:0];
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cycles_q   <= cycles_d;
      base_pc_q  <= base_pc_d;
      end_pc_q   <= end_pc_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      core_rst_q <= (state_d == IDLE) || (state_d == RST);
      core_en_q  <= (state_d == RUN);
      busy_q     <= (state_d == RST) || (state_d == RUN);
    end
  end

  assign bus.core_rst = core_rst_q | rst;
  assign bus.core_en  = core_en_q;
  assign bus.base_pc  = base_pc_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = busy_q;
  assign bus.cycles   = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: three configurations driven one at a time,
// expected run outcomes queued by stimulus and popped by a negedge monitor.
module tb_run_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  run_ctrl_if #(.PC_W(8), .PSEL_W(1), .CYC_W(16)) if0 ();
  run_ctrl_if #(.PC_W(8), .PSEL_W(2), .CYC_W(16)) if1 ();
  run_ctrl_if #(.PC_W(8), .PSEL_W(1), .CYC_W(16)) if2 ();

  run_ctrl u0 (.clk(clk), .rst(rst), .bus(if0.slave));

  run_ctrl #(
    .NUM_PROGS(2), .PSEL_W(2),
    .PROG_BASE({8'd100, 8'd0}), .PROG_END({8'd120, 8'd50}),
    .RST_CYCLES(3)
  ) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  run_ctrl #(
    .NUM_PROGS(2), .PSEL_W(1),
    .PROG_BASE({8'd0, 8'd0}), .PROG_END({8'd9, 8'd200}),
    .RST_CYCLES(2), .MAX_CYCLES(10)
  ) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic       st   [3];
  logic [1:0] ps   [3];
  logic [7:0] pcm  [3];
  logic       o_crst [3];
  logic       o_cen  [3];
  logic       o_done [3];
  logic       o_to   [3];
  logic       o_busy [3];
  logic [15:0] o_cyc [3];
  logic [7:0]  o_base[3];

  assign if0.start = st[0];  assign if0.prog_sel = ps[0][0:0];  assign if0.pc = pcm[0];
  assign if1.start = st[1];  assign if1.prog_sel = ps[1];       assign if1.pc = pcm[1];
  assign if2.start = st[2];  assign if2.prog_sel = ps[2][0:0];  assign if2.pc = pcm[2];

  assign o_crst[0] = if0.core_rst; assign o_cen[0] = if0.core_en; assign o_done[0] = if0.done;
  assign o_to[0]   = if0.timeout;  assign o_busy[0] = if0.busy;  assign o_cyc[0] = if0.cycles;
  assign o_base[0] = if0.base_pc;
  assign o_crst[1] = if1.core_rst; assign o_cen[1] = if1.core_en; assign o_done[1] = if1.done;
  assign o_to[1]   = if1.timeout;  assign o_busy[1] = if1.busy;  assign o_cyc[1] = if1.cycles;
  assign o_base[1] = if1.base_pc;
  assign o_crst[2] = if2.core_rst; assign o_cen[2] = if2.core_en; assign o_done[2] = if2.done;
  assign o_to[2]   = if2.timeout;  assign o_busy[2] = if2.busy;  assign o_cyc[2] = if2.cycles;
  assign o_base[2] = if2.base_pc;

  // Simple cores: load base_pc while held in reset, count up while enabled.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (o_crst[i])     pcm[i] <= o_base[i];
      else if (o_cen[i]) pcm[i] <= pcm[i] + 8'd1;
    end
  end

  typedef struct {
    int id;
    bit is_done;
    bit to;
    int cyc;
    int base;
    int rlen;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: program table per configuration and resulting run length.
  task automatic prog_info(input int id, input int sel, output int base, output int endp,
                           output int rlen, output int maxc);
    int np  = (id == 0) ? 1 : 2;
    int eff = (sel < np) ? sel : 0;
    base = 0; endp = 190; rlen = 1; maxc = 0;
    if (id == 1) begin
      base = (eff == 1) ? 100 : 0;
      endp = (eff == 1) ? 120 : 50;
      rlen = 3;
    end else if (id == 2) begin
      endp = (eff == 1) ? 9 : 200;
      rlen = 2;
      maxc = 10;
    end
  endtask

  task automatic run_len(input int id, input int sel, output int len, output bit tmo);
    int base, endp, rlen, maxc, nm;
    prog_info(id, sel, base, endp, rlen, maxc);
    nm  = ((endp - base) & 255) + 1;
    tmo = (maxc != 0) && (maxc < nm);
    len = tmo ? maxc : nm;
  endtask

  // Monitor: completion (done rising) or abort (busy falling without done).
  bit pb[3];
  bit pd[3];
  bit seen_en[3];
  int rcnt[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        if (o_busy[i] && o_crst[i]) rcnt[i]++;
        if (o_cen[i] && !seen_en[i]) begin
          seen_en[i] = 1'b1;
          if (sbq.size() > 0) chk("rst_len", rcnt[i], sbq[0].rlen);
        end
        if ((o_done[i] && !pd[i]) || (pb[i] && !o_busy[i] && !o_done[i])) begin
          if (sbq.size() == 0) begin
            chk("unexpected_event", 1, sbq.size());
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("ev_id",      i,              e.id);
            chk("ev_done",    int'(o_done[i]), int'(e.is_done));
            chk("ev_timeout", int'(o_to[i]),   int'(e.to));
            chk("ev_cycles",  int'(o_cyc[i]),  e.cyc);
            chk("ev_base_pc", int'(o_base[i]), e.base);
          end
          rcnt[i]    = 0;
          seen_en[i] = 1'b0;
        end
      end else begin
        rcnt[i]    = 0;
        seen_en[i] = 1'b0;
      end
      pb[i] = o_busy[i];
      pd[i] = o_done[i];
    end
  end

  // abort_k: 0 = run to completion, >0 = drop start in RUN cycle k, <0 = drop in RST.
  task automatic do_run(input int id, input int sel, input int abort_k);
    int base, endp, rlen, maxc, len, n, hold;
    bit tmo;
    logic [7:0] p0;
    exp_t e;
    prog_info(id, sel, base, endp, rlen, maxc);
    run_len(id, sel, len, tmo);
    e.id = id; e.base = base; e.rlen = rlen;
    e.is_done = (abort_k == 0);
    e.to      = (abort_k == 0) && tmo;
    e.cyc     = (abort_k > 0) ? abort_k : ((abort_k < 0) ? 0 : len);
    sbq.push_back(e);

    ps[id] = 2'(sel);
    st[id] = 1'b1;
    @(negedge clk);
    chk("start_busy",   int'(o_busy[id]), 1);
    chk("start_cycles", int'(o_cyc[id]),  0);
    if (abort_k < 0) begin
      st[id] = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_abort_core_rst", int'(o_crst[id]), 1);
      return;
    end
    n = 0;
    while (!o_cen[id] && n < 10) begin @(negedge clk); n++; end
    chk("core_en_wait", int'(o_cen[id]), 1);
    if (abort_k > 0) begin
      repeat (abort_k - 1) @(negedge clk);
      st[id] = 1'b0;
      @(negedge clk);
      chk("abort_core_rst", int'(o_crst[id]), 1);
      chk("abort_done",     int'(o_done[id]), 0);
      @(negedge clk);
      return;
    end
    n = 0;
    while (!o_done[id] && n < 400) begin @(negedge clk); n++; end
    chk("done_wait", int'(o_done[id]), 1);
    p0   = pcm[id];
    hold = $urandom_range(1, 3);
    repeat (hold) @(negedge clk);
    chk("hold_done",    int'(o_done[id]), 1);
    chk("hold_busy",    int'(o_busy[id]), 0);
    chk("hold_core_en", int'(o_cen[id]),  0);
    chk("hold_pc",      int'(pcm[id]),    int'(p0));
    st[id] = 1'b0;
    @(negedge clk);
    chk("idle_done",     int'(o_done[id]), 0);
    chk("idle_timeout",  int'(o_to[id]),   0);
    chk("idle_cycles",   int'(o_cyc[id]),  len);
    chk("idle_core_rst", int'(o_crst[id]), 1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int id, sel, len, r, k;
    bit tmo;
    exp_t e;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; ps[i] = 2'd0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_core_rst", int'(o_crst[i]), 1);
      chk("rst_core_en",  int'(o_cen[i]),  0);
      chk("rst_done",     int'(o_done[i]), 0);
      chk("rst_timeout",  int'(o_to[i]),   0);
      chk("rst_busy",     int'(o_busy[i]), 0);
      chk("rst_cycles",   int'(o_cyc[i]),  0);
      chk("rst_base_pc",  int'(o_base[i]), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_run(0, 0, 0);
    do_run(1, 1, 0);
    do_run(1, 3, 0);
    do_run(2, 0, 0);
    do_run(2, 1, 0);
    do_run(0, 0, 5);
    do_run(0, 0, 0);
    do_run(1, 1, -1);

    // Asynchronous reset in the middle of a prog-1 run on u1.
    e.id = 1; e.is_done = 1'b0; e.to = 1'b0; e.cyc = 0; e.base = 0; e.rlen = 3;
    sbq.push_back(e);
    ps[1] = 2'd1;
    st[1] = 1'b1;
    repeat (8) @(negedge clk);
    chk("pre_rst_core_en", int'(o_cen[1]), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_core_rst", int'(o_crst[1]), 1);
    chk("async_core_en",  int'(o_cen[1]),  0);
    chk("async_done",     int'(o_done[1]), 0);
    chk("async_cycles",   int'(o_cyc[1]),  0);
    chk("async_base_pc",  int'(o_base[1]), 0);
    #1 st[1] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 20; t++) begin
      id  = $urandom_range(0, 2);
      sel = (id == 1) ? $urandom_range(0, 3) : ((id == 2) ? $urandom_range(0, 1) : 0);
      run_len(id, sel, len, tmo);
      r = $urandom_range(0, 3);
      if (r == 0)                k = $urandom_range(1, len);
      else if (r == 1 && id == 1) k = -1;
      else                       k = 0;
      do_run(id, sel, k);
    end

    repeat (2) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
